// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush/redirect controller.
package pipeline_ctrl_pkg;

  // Width of the hold vector and the pipeline register each bit freezes.
  localparam int HOLD_BUS   = 4;
  localparam int HOLD_PC    = 0;
  localparam int HOLD_IFID  = 1;
  localparam int HOLD_IDEX  = 2;
  localparam int HOLD_EXMEM = 3;

  // General exception entry address (BEV=1 bootstrap vector).
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_stall_merge.sv
// Priority encoder from per-stage stall requests to the pipeline hold vector.
// The latest stage wins: it freezes itself and every earlier stage.
module stall_merge
  import pipeline_ctrl_pkg::*;
(
  input  logic                stall_req_if,
  input  logic                stall_req_id,
  input  logic                stall_req_ex,
  input  logic                stall_req_mem,
  output logic [HOLD_BUS-1:0] hold
);

  // Latest-stage request selects the hold pattern.
  always_comb begin
    hold = '0;
    if (stall_req_mem)     hold = 4'b1111;
    else if (stall_req_ex) hold = 4'b0111;
    else if (stall_req_id) hold = 4'b0011;
    else if (stall_req_if) hold = 4'b0001;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline.
// Owns the single PC redirect port: exception/ERET flush sequencing,
// live and deferred branch redirects, plus a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(EXC_VECTOR_DEFAULT),
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  exc_valid,
  input  logic                  exc_is_eret,
  input  logic [ADDR_WIDTH-1:0] cp0_epc,
  output logic [HOLD_BUS-1:0]   hold,
  output logic                  flush,
  output logic                  pc_redirect_en,
  output logic [ADDR_WIDTH-1:0] pc_redirect_addr,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  ctrl_state_e           state, state_next;
  logic [HOLD_BUS-1:0]   hold_req;
  logic [HOLD_BUS-1:0]   hold_c;
  logic                  flush_c, redir_en_c;
  logic [ADDR_WIDTH-1:0] redir_addr_c;
  logic [ADDR_WIDTH-1:0] exc_target;
  logic                  branch_pending;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  exc_accept;
  logic                  id_advance;
  logic                  branch_live;
  logic                  branch_defer;

  stall_merge u_merge (
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .hold          (hold_req)
  );

  // A held ID stage will re-present its branch, so only an advancing one counts.
  assign id_advance   = ~hold_req[HOLD_IFID];
  assign branch_live  = branch_flag & id_advance & ~hold_req[HOLD_PC];
  assign branch_defer = branch_flag & id_advance &  hold_req[HOLD_PC];

  // Next state and redirect/flush/hold outputs; exception beats pending beats live.
  always_comb begin
    state_next   = state;
    hold_c       = hold_req;
    flush_c      = 1'b0;
    redir_en_c   = 1'b0;
    redir_addr_c = '0;
    exc_accept   = 1'b0;
    case (state)
      ST_RUN: begin
        // A MEM-stage stall means the excepting instruction is not yet final.
        exc_accept = exc_valid & ~stall_req_mem;
        if (exc_accept) begin
          state_next = ST_FLUSH;
        end else if (branch_pending) begin
          redir_en_c   = 1'b1;
          redir_addr_c = branch_target;
        end else if (branch_live) begin
          redir_en_c   = 1'b1;
          redir_addr_c = branch_addr;
        end
      end
      ST_FLUSH: begin
        flush_c      = 1'b1;
        redir_en_c   = 1'b1;
        redir_addr_c = exc_target;
        hold_c       = '0;
        state_next   = stall_req_if ? ST_REDIRECT : ST_RUN;
      end
      ST_REDIRECT: begin
        // Keep the redirect asserted until fetch can accept the new PC.
        redir_en_c       = 1'b1;
        redir_addr_c     = exc_target;
        hold_c           = '0;
        hold_c[HOLD_PC]  = stall_req_if;
        state_next       = stall_req_if ? ST_REDIRECT : ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Outputs read as zero for as long as reset is asserted.
  always_comb begin
    hold             = rst ? '0 : hold_c;
    flush            = rst ? 1'b0 : flush_c;
    pc_redirect_en   = rst ? 1'b0 : redir_en_c;
    pc_redirect_addr = rst ? '0 : redir_addr_c;
  end

  // State register and exception target capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      exc_target <= '0;
    end else begin
      state <= state_next;
      if (exc_accept) exc_target <= exc_is_eret ? cp0_epc : EXC_VECTOR;
    end
  end

  // Deferred branch latch: holds a target that arrived while the PC was frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_pending <= 1'b0;
      branch_target  <= '0;
    end else if (exc_accept) begin
      branch_pending <= 1'b0;
    end else if (state == ST_RUN) begin
      if (branch_pending) begin
        if (!hold_req[HOLD_PC]) branch_pending <= 1'b0;
      end else if (branch_defer) begin
        branch_pending <= 1'b1;
        branch_target  <= branch_addr;
      end
    end
  end

  // Saturating count of RUN cycles with the PC frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else if (state == ST_RUN && hold_req[HOLD_PC] && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        exc_valid, exc_is_eret;
  logic [31:0] cp0_epc;
  logic [3:0]  hold;
  logic        flush;
  logic        pc_redirect_en;
  logic [31:0] pc_redirect_addr;
  logic [3:0]  stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.ADDR_WIDTH(32), .EXC_VECTOR(32'hBFC00380), .CNT_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_req_if     (stall_req_if),
    .stall_req_id     (stall_req_id),
    .stall_req_ex     (stall_req_ex),
    .stall_req_mem    (stall_req_mem),
    .branch_flag      (branch_flag),
    .branch_addr      (branch_addr),
    .exc_valid        (exc_valid),
    .exc_is_eret      (exc_is_eret),
    .cp0_epc          (cp0_epc),
    .hold             (hold),
    .flush            (flush),
    .pc_redirect_en   (pc_redirect_en),
    .pc_redirect_addr (pc_redirect_addr),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
    branch_flag = 0; branch_addr = 0; exc_valid = 0; exc_is_eret = 0;
  endtask

  initial begin
    idle();
    cp0_epc = 32'h80001004;
    rst = 1;
    #2;
    chk("rst_hold", {28'd0, hold}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_en", {31'd0, pc_redirect_en}, 0);
    chk("rst_addr", pc_redirect_addr, 0);
    chk("rst_cnt", {28'd0, stall_cycles}, 0);
    step(); step();
    rst = 0;
    step();

    // EX + ID stall for three cycles
    stall_req_ex = 1; stall_req_id = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("ex_hold", {28'd0, hold}, 32'h7);
      step();
    end
    idle();
    #2 chk("ex_cnt", {28'd0, stall_cycles}, 3);
    chk("idle_hold", {28'd0, hold}, 0);

    // Live branch: combinational pass-through
    branch_flag = 1; branch_addr = 32'h00001234;
    #2 chk("live_en", {31'd0, pc_redirect_en}, 1);
    chk("live_addr", pc_redirect_addr, 32'h00001234);
    step();

    // Deferred branch while fetch stalls
    stall_req_if = 1; branch_addr = 32'h00400020;
    #2 chk("def_hold", {28'd0, hold}, 32'h1);
    chk("def_en0", {31'd0, pc_redirect_en}, 0);
    step();
    branch_flag = 0; branch_addr = 0;
    #2 chk("pend_en", {31'd0, pc_redirect_en}, 1);
    chk("pend_addr", pc_redirect_addr, 32'h00400020);
    step();
    stall_req_if = 0;
    #2 chk("pend_last_en", {31'd0, pc_redirect_en}, 1);
    chk("pend_last_addr", pc_redirect_addr, 32'h00400020);
    step();
    #2 chk("pend_clr_en", {31'd0, pc_redirect_en}, 0);
    chk("pend_cnt", {28'd0, stall_cycles}, 5);

    // Branch while ID held is ignored
    stall_req_ex = 1; branch_flag = 1; branch_addr = 32'h00000abc;
    #2 chk("idheld_en", {31'd0, pc_redirect_en}, 0);
    step();
    idle();
    #2 chk("idheld_nopend", {31'd0, pc_redirect_en}, 0);
    chk("idheld_cnt", {28'd0, stall_cycles}, 6);

    // Exception accept then single-cycle FLUSH to the vector
    exc_valid = 1;
    #2 chk("exc_acc_flush", {31'd0, flush}, 0);
    chk("exc_acc_en", {31'd0, pc_redirect_en}, 0);
    step();
    idle(); stall_req_ex = 1;
    #2 chk("exc_flush", {31'd0, flush}, 1);
    chk("exc_flush_en", {31'd0, pc_redirect_en}, 1);
    chk("exc_flush_addr", pc_redirect_addr, 32'hBFC00380);
    chk("exc_flush_hold", {28'd0, hold}, 0);
    step();
    idle();
    #2 chk("exc_after_flush", {31'd0, flush}, 0);
    chk("exc_after_en", {31'd0, pc_redirect_en}, 0);
    chk("exc_cnt", {28'd0, stall_cycles}, 6);

    // ERET with fetch busy for two cycles after accept
    exc_valid = 1; exc_is_eret = 1;
    step();
    idle(); stall_req_if = 1;
    #2 chk("eret_flush", {31'd0, flush}, 1);
    chk("eret_addr", pc_redirect_addr, 32'h80001004);
    chk("eret_hold", {28'd0, hold}, 0);
    step();
    exc_valid = 1;
    #2 chk("redir_flush", {31'd0, flush}, 0);
    chk("redir_en", {31'd0, pc_redirect_en}, 1);
    chk("redir_addr", pc_redirect_addr, 32'h80001004);
    chk("redir_hold", {28'd0, hold}, 32'h1);
    step();
    idle();
    #2 chk("redir_last_en", {31'd0, pc_redirect_en}, 1);
    chk("redir_last_addr", pc_redirect_addr, 32'h80001004);
    chk("redir_last_hold", {28'd0, hold}, 0);
    step();
    #2 chk("redir_done_en", {31'd0, pc_redirect_en}, 0);
    chk("redir_noexc", {31'd0, flush}, 0);
    step();
    #2 chk("redir_noexc2", {31'd0, flush}, 0);
    chk("eret_cnt", {28'd0, stall_cycles}, 6);

    // Exception blocked by MEM stall, then collides with a branch
    exc_valid = 1; stall_req_mem = 1;
    #2 chk("mem_hold", {28'd0, hold}, 32'hF);
    step();
    #2 chk("mem_noflush", {31'd0, flush}, 0);
    step();
    #2 chk("mem_noflush2", {31'd0, flush}, 0);
    stall_req_mem = 0; branch_flag = 1; branch_addr = 32'h00000055;
    #1 chk("coll_en", {31'd0, pc_redirect_en}, 0);
    step();
    idle();
    #2 chk("coll_flush", {31'd0, flush}, 1);
    chk("coll_addr", pc_redirect_addr, 32'hBFC00380);
    step();
    #2 chk("coll_nobranch", {31'd0, pc_redirect_en}, 0);
    chk("mem_cnt", {28'd0, stall_cycles}, 8);

    // Reset while in REDIRECT
    exc_valid = 1;
    step();
    idle(); stall_req_if = 1;
    step();
    #2 chk("pre_rst_en", {31'd0, pc_redirect_en}, 1);
    rst = 1;
    #1 chk("rr_hold", {28'd0, hold}, 0);
    chk("rr_en", {31'd0, pc_redirect_en}, 0);
    chk("rr_addr", pc_redirect_addr, 0);
    chk("rr_cnt", {28'd0, stall_cycles}, 0);
    step();
    stall_req_if = 0;
    rst = 0;
    #2 chk("rr_run_en", {31'd0, pc_redirect_en}, 0);
    chk("rr_run_flush", {31'd0, flush}, 0);

    // Counter saturation at 4 bits
    stall_req_ex = 1;
    for (int i = 0; i < 20; i++) step();
    idle();
    #2 chk("cnt_sat", {28'd0, stall_cycles}, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush/redirect controller for the 5-stage MIPS pipeline.
- Merges stall requests from IF (fetch wait), ID (load-use), EX (multi-cycle mult/div) and MEM (data bus wait) into one hold vector.
- Sequences exception/ERET flushes and owns the single PC redirect port.
- Latches branch targets from ID that arrive while the PC is frozen.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
ADDR_WIDTH, 32, width of PC/target addresses
EXC_VECTOR, 32'hBFC00380, general exception entry address
CNT_WIDTH, 32, stall counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
stall_req_if  input  1  fetch not complete
stall_req_id  input  1  load-use hazard (load_related_1|load_related_2)
stall_req_ex  input  1  multi-cycle EX op busy
stall_req_mem  input  1  data access not complete
branch_flag  input  1  ID resolved taken branch/jump
branch_addr  input  ADDR_WIDTH  ID branch target
exc_valid  input  1  MEM-stage instruction raises exception or is ERET
exc_is_eret  input  1  qualifies exc_valid: ERET
cp0_epc  input  ADDR_WIDTH  current CP0 EPC
hold  output  4  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM; 1 = register keeps value
flush  output  1  clear all pipeline registers
pc_redirect_en  output  1  PC loads pc_redirect_addr
pc_redirect_addr  output  ADDR_WIDTH  redirect target
stall_cycles  output  CNT_WIDTH  saturating count of cycles with hold[0]=1

Behaviour:
- Reset: hold=0, flush=0, pc_redirect_en=0, pc_redirect_addr=0, stall_cycles=0, state=RUN, branch_pending=0.
- hold is combinational from requests. The latest-stage request wins:
  - mem → 4'b1111
  - ex → 4'b0111
  - id → 4'b0011
  - if → 4'b0001
  - none → 0
- Bubble rules: register k+1 loads a bubble when hold[k]=1 and hold[k+1]=0. MEM/WB loads a bubble when hold[3]=1.
- ID advances when hold[1]=0.
- FSM states: RUN, FLUSH, REDIRECT.
- RUN:
  - exc_valid is accepted only when stall_req_mem=0. On accept, register target = exc_is_eret ? cp0_epc : EXC_VECTOR, then go to FLUSH.
- FLUSH (exactly 1 cycle):
  - flush=1, pc_redirect_en=1, pc_redirect_addr=target, hold forced to 0.
  - Next state is RUN if stall_req_if=0, else REDIRECT.
- REDIRECT:
  - flush=0; pc_redirect_en=1 with the same target; hold forced to 0 except hold[0] follows stall_req_if.
  - Leaves to RUN in the cycle stall_req_if=0; redirect takes effect that cycle.
  - exc_valid is ignored in FLUSH/REDIRECT.
- Branch handling in RUN:
  - Live branch: branch_flag & ID advancing & hold[0]=0 → pc_redirect_en=1, addr=branch_addr, combinational pass-through.
  - Deferred branch: branch_flag & ID advancing & hold[0]=1 → set branch_pending, latch branch_addr.
  - While pending, pc_redirect_en=1 with the latched address. Pending clears on the first cycle with hold[0]=0.
  - branch_flag is ignored when ID is held, because the instruction will re-present.
- Priority: exception accept > pending branch > live branch. Entering FLUSH clears branch_pending. A branch_flag arriving in the same cycle as an exception accept is dropped.
- stall_cycles: increments when hold[0]=1 in RUN; saturates at all-ones; no wrap.
- Reset mid-FLUSH/REDIRECT: immediate return to RUN with all outputs zero; the pending target is lost.
- Combinational paths input→hold and input→redirect are allowed. The registered state must not depend on hold in the same cycle except through the defined terms.

Decomposition:
- Shared header additions:
  - HOLD_BUS (3:0)
  - hold bit indices HOLD_PC/HOLD_IFID/HOLD_IDEX/HOLD_EXMEM
  - EXC_VECTOR default
  - FSM state encodings
- One sub-module: stall_merge, the combinational priority encoder from the four requests to hold.
- FSM, branch latch and counter stay in pipeline_ctrl.

Test Plan:
- stall_req_ex=1 for 3 cycles with stall_req_id=1 → hold=4'b0111 each cycle; stall_cycles increments 0→3.
- stall_req_if=1, branch_flag=1, branch_addr=0x00400020 → branch_pending set; redirect_en held with 0x00400020 until if drops, then cleared next cycle.
- exc_valid=1, exc_is_eret=0, stall_req_mem=0 → next cycle flush=1 for exactly 1 cycle, pc_redirect_addr=0xBFC00380, hold=0.
- exc_valid=1, exc_is_eret=1, cp0_epc=0x80001004, stall_req_if=1 for 2 cycles after accept → flush 1 cycle, redirect_en asserted 3 cycles at 0x80001004, then RUN.
- exc_valid=1 with stall_req_mem=1 → no flush until mem drops. Simultaneous exception and branch → target = exception target, branch_pending=0.
- Assert rst in REDIRECT → all outputs 0 asynchronously; release → RUN, no redirect.
